// File: rtl/handshake_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module   : handshake_sync_pkg
// Brief    : Shared FSM state type and default sizing for handshake_sync_tx.
// Revision : 1.0
// ============================================================================
package handshake_sync_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int c_DEF_N   = 1;
  localparam int c_DEF_D   = 2;
  localparam int c_DEF_TMO = 1024;

endpackage
`default_nettype wire

// File: rtl/bit_sync.sv
`default_nettype none
// ============================================================================
// Module   : bit_sync
// Brief    : D-stage single-bit synchronizer, async active-high reset to 0.
// Revision : 1.0
// ============================================================================
module bit_sync
  import handshake_sync_pkg::c_DEF_D;
#(
  parameter int D = c_DEF_D
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [D-1:0] r_stage;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage <= '0;
    end else begin
      r_stage <= {r_stage[D-2:0], d};
    end
  end

  assign q = r_stage[D-1];

endmodule
`default_nettype wire

// File: rtl/handshake_sync_tx.sv
`default_nettype none
// ============================================================================
// Module   : handshake_sync_tx
// Brief    : Toggle-handshake transmitter from the sclk domain to a slow sink.
//            Optional ack timeout flag: define HANDSHAKE_SYNC_TX_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module handshake_sync_tx
  import handshake_sync_pkg::*;
#(
  parameter int N   = c_DEF_N,
  parameter int D   = c_DEF_D,
  parameter int TMO = c_DEF_TMO
) (
  input  logic         sclk,
  input  logic         srst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [N-1:0] s_data,
  output logic         xreq,
  output logic [N-1:0] xdat,
  input  logic         xack
`ifdef HANDSHAKE_SYNC_TX_TIMEOUT_EN
  ,
  output logic         s_timeout
`endif
);

  state_t       r_state;
  state_t       w_state_nxt;
  logic         w_ack_s;
  logic         r_ack_q;
  logic         w_accept;
  logic         r_xreq;
  logic [N-1:0] r_xdat;

  bit_sync #(
    .D (D)
  ) u_ack_sync (
    .clk (sclk),
    .rst (srst),
    .d   (xack),
    .q   (w_ack_s)
  );

  // Extra compare register: completion lands D+1 edges after xack is first sampled.
  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      r_ack_q <= 1'b0;
    end else begin
      r_ack_q <= w_ack_s;
    end
  end

  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (s_valid && s_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (r_ack_q == r_xreq) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      r_xreq <= 1'b0;
      r_xdat <= '0;
    end else if (w_accept) begin
      r_xreq <= ~r_xreq;
      r_xdat <= s_data;
    end
  end

  assign s_ready = (r_state == IDLE) && !srst;
  assign xreq    = r_xreq;
  assign xdat    = r_xdat;

`ifdef HANDSHAKE_SYNC_TX_TIMEOUT_EN
  localparam int c_CW = $clog2(TMO + 1);

  logic [c_CW-1:0] r_cnt;
  logic            r_timeout;

  // The FSM keeps waiting after a timeout; the flag only reports it.
  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if ((r_state == WAIT) && (r_cnt != c_CW'(TMO))) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == c_CW'(TMO - 1)) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign s_timeout = r_timeout;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TMO > 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_handshake_sync_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_handshake_sync_tx
// Brief    : Self-checking bench for handshake_sync_tx (N=8, D=2, TMO=16).
// Revision : 1.0
// ============================================================================
module tb_handshake_sync_tx;

  localparam int N   = 8;
  localparam int D   = 2;
  localparam int TMO = 16;

  logic         sclk    = 1'b0;
  logic         srst    = 1'b1;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [N-1:0] s_data  = '0;
  logic         xreq;
  logic [N-1:0] xdat;
  logic         xack    = 1'b0;
`ifdef HANDSHAKE_SYNC_TX_TIMEOUT_EN
  logic         s_timeout;
`endif

  always #5 sclk = ~sclk;

  handshake_sync_tx #(
    .N   (N),
    .D   (D),
    .TMO (TMO)
  ) dut (
    .sclk    (sclk),
    .srst    (srst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .xreq    (xreq),
    .xdat    (xdat),
    .xack    (xack)
`ifdef HANDSHAKE_SYNC_TX_TIMEOUT_EN
    ,
    .s_timeout (s_timeout)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level reference: busy flag, request parity, held data.
  bit           m_busy = 1'b0;
  bit           m_xreq = 1'b0;
  logic [N-1:0] m_xdat = '0;
  bit           m_acc  = 1'b0;
  bit           ackq[0:D];
`ifdef HANDSHAKE_SYNC_TX_TIMEOUT_EN
  int           m_cnt  = 0;
  bit           m_to   = 1'b0;
`endif

  bit           resp_en  = 1'b0;
  int           resp_dly = 3;
  int           resp_cnt = 0;
  logic [N-1:0] seen_dat[$];
  bit           seen_req[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // The FSM sees xack D+1 edges after it is first sampled.
  task automatic model_edge();
    bit dly_ack;
    m_acc   = 1'b0;
    dly_ack = ackq[0];
    for (int i = 0; i < D; i++) ackq[i] = ackq[i+1];
    ackq[D] = xack;
    if (srst) begin
      m_busy = 1'b0;
      m_xreq = 1'b0;
      m_xdat = '0;
      for (int i = 0; i <= D; i++) ackq[i] = 1'b0;
`ifdef HANDSHAKE_SYNC_TX_TIMEOUT_EN
      m_cnt = 0;
      m_to  = 1'b0;
`endif
    end else if (!m_busy) begin
      if (s_valid) begin
        m_acc  = 1'b1;
        m_busy = 1'b1;
        m_xreq = !m_xreq;
        m_xdat = s_data;
`ifdef HANDSHAKE_SYNC_TX_TIMEOUT_EN
        m_cnt = 0;
`endif
      end
    end else begin
`ifdef HANDSHAKE_SYNC_TX_TIMEOUT_EN
      m_cnt = (m_cnt < TMO) ? m_cnt + 1 : TMO;
      if (m_cnt == TMO) m_to = 1'b1;
`endif
      if (dly_ack == m_xreq) m_busy = 1'b0;
    end
  endtask

  task automatic cycle();
    if (resp_en && (xack != m_xreq)) begin
      if (resp_cnt >= resp_dly) begin
        xack     = m_xreq;
        resp_cnt = 0;
      end else begin
        resp_cnt++;
      end
    end else begin
      resp_cnt = 0;
    end
    model_edge();
    @(posedge sclk);
    #1;
    check("s_ready", s_ready, {31'd0, !m_busy && !srst});
    check("xreq", xreq, {31'd0, m_xreq});
    check("xdat", xdat, {24'd0, m_xdat});
`ifdef HANDSHAKE_SYNC_TX_TIMEOUT_EN
    check("s_timeout", s_timeout, {31'd0, m_to});
`endif
    if (m_acc) begin
      seen_dat.push_back(xdat);
      seen_req.push_back(xreq);
    end
  endtask

  task automatic do_reset(input int n);
    srst = 1'b1;
    xack = 1'b0;
    repeat (n) cycle();
    srst = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int t = 0; t < 60 && m_busy; t++) cycle();
    check(tag, s_ready, 32'd1);
  endtask

  initial begin
    logic [N-1:0] bb [3];
    int           idx;
    bb[0] = 8'h01;
    bb[1] = 8'h02;
    bb[2] = 8'h03;
    for (int i = 0; i <= D; i++) ackq[i] = 1'b0;

    // Reset state, then ready on the first edge after release.
    repeat (3) cycle();
    check("rst_xreq", xreq, 32'd0);
    check("rst_xdat", xdat, 32'd0);
    check("rst_ready", s_ready, 32'd0);
    srst = 1'b0;
    cycle();
    check("rst_release_ready", s_ready, 32'd1);

    // Single transfer: xack sampled at k+4, ready returns after k+7.
    s_valid = 1'b1;
    s_data  = 8'hA5;
    cycle();
    s_valid = 1'b0;
    check("single_xdat", xdat, 32'hA5);
    check("single_xreq", xreq, 32'd1);
    check("single_busy", s_ready, 32'd0);
    repeat (3) cycle();
    xack = 1'b1;
    repeat (3) cycle();
    check("single_ready_k6", s_ready, 32'd0);
    cycle();
    check("single_ready_k7", s_ready, 32'd1);
    repeat (2) cycle();

    // Back-to-back with a 3-cycle responder from a fresh reset.
    do_reset(1);
    seen_dat.delete();
    seen_req.delete();
    resp_en  = 1'b1;
    resp_dly = 3;
    idx      = 0;
    s_valid  = 1'b1;
    s_data   = bb[0];
    for (int t = 0; t < 80 && idx < 3; t++) begin
      cycle();
      if (m_acc) begin
        idx++;
        if (idx < 3) s_data = bb[idx];
        else s_valid = 1'b0;
      end
    end
    s_valid = 1'b0;
    wait_idle("b2b_drain");
    check("b2b_count", seen_dat.size(), 32'd3);
    for (int i = 0; i < 3 && i < seen_dat.size(); i++) begin
      check("b2b_data", seen_dat[i], {24'd0, bb[i]});
      check("b2b_xreq", seen_req[i], (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    resp_en = 1'b0;

    // Hold: s_data churns during WAIT; the next accept takes IDLE-time data.
    s_valid = 1'b1;
    s_data  = 8'h77;
    cycle();
    s_data = 8'h10;
    cycle();
    s_data = 8'h20;
    cycle();
    s_data = 8'h30;
    cycle();
    check("hold_xdat", xdat, 32'h77);
    xack = m_xreq;
    for (int t = 0; t < 20 && m_busy; t++) cycle();
    cycle();
    check("hold_next_xdat", xdat, 32'h30);
    s_valid = 1'b0;
    xack    = m_xreq;
    wait_idle("hold_drain");

    // Reset in the middle of WAIT, then a fresh transfer.
    do_reset(1);
    s_valid = 1'b1;
    s_data  = 8'h33;
    cycle();
    s_valid = 1'b0;
    check("midrst_pre_xreq", xreq, 32'd1);
    do_reset(2);
    cycle();
    check("midrst_xreq", xreq, 32'd0);
    check("midrst_ready", s_ready, 32'd1);
    s_valid = 1'b1;
    s_data  = 8'h5A;
    cycle();
    s_valid = 1'b0;
    check("midrst_next_xreq", xreq, 32'd1);
    check("midrst_next_xdat", xdat, 32'h5A);
    xack = 1'b1;
    wait_idle("midrst_drain");

    // Spurious ack toggle while idle must not block acceptance.
    xack = !xack;
    repeat (5) cycle();
    check("spur_ready", s_ready, 32'd1);
    s_valid = 1'b1;
    s_data  = 8'hE7;
    cycle();
    s_valid = 1'b0;
    check("spur_accept_xdat", xdat, 32'hE7);
    resp_en  = 1'b1;
    resp_dly = 2;
    wait_idle("spur_drain");
    resp_en = 1'b0;

`ifdef HANDSHAKE_SYNC_TX_TIMEOUT_EN
    do_reset(1);
    s_valid = 1'b1;
    s_data  = 8'hC3;
    cycle();
    s_valid = 1'b0;
    repeat (TMO - 1) cycle();
    check("tmo_before", s_timeout, 32'd0);
    cycle();
    check("tmo_set", s_timeout, 32'd1);
    repeat (3) cycle();
    xack = m_xreq;
    wait_idle("tmo_complete");
    check("tmo_sticky", s_timeout, 32'd1);
    do_reset(1);
    cycle();
    check("tmo_cleared", s_timeout, 32'd0);
`endif

    // Randomized traffic with random responder delays and rare resets.
    do_reset(1);
    resp_en = 1'b1;
    for (int t = 0; t < 400; t++) begin
      s_valid = ($urandom_range(0, 2) != 0);
      s_data  = N'($urandom);
      if (resp_cnt == 0) resp_dly = $urandom_range(0, 5);
      if ($urandom_range(0, 99) == 0) begin
        srst = 1'b1;
        xack = 1'b0;
      end else begin
        srst = 1'b0;
      end
      cycle();
    end
    srst    = 1'b0;
    s_valid = 1'b0;
    wait_idle("rand_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/handshake_sync_tx.md
HANDSHAKE_SYNC_TX -- requirements
Module: handshake_sync_tx

Interface
REQ-001 The block SHALL have parameter N, default 1, meaning data width in bits (N >= 1).
REQ-002 The block SHALL have parameter D, default 2, meaning number of acknowledge synchronizer stages (D >= 2).
REQ-003 The block SHALL have parameter TMO, default 1024, meaning acknowledge timeout in sclk cycles (used only under REQ-024).
REQ-004 sclk  input  1  source core clock, the only clock.
REQ-005 srst  input  1  source core reset, asynchronous, active-high.
REQ-006 s_valid  input  1  source offers s_data.
REQ-007 s_ready  output  1  block can accept; transfer occurs when s_valid && s_ready at a sclk rising edge.
REQ-008 s_data  input  N  source data.
REQ-009 xreq  output  1  toggle request to the slow sink domain; register output.
REQ-010 xdat  output  N  held data to the sink domain; register output.
REQ-011 xack  input  1  toggle acknowledge from the sink domain; asynchronous to sclk.

Function
REQ-012 xack SHALL pass through a D-stage synchronizer; its final stage output is ack_s.
REQ-013 The FSM SHALL have states IDLE and WAIT; s_ready SHALL be 1 exactly when state is IDLE and srst is low.
REQ-014 In IDLE, on s_valid && s_ready at an edge: xdat <= s_data, xreq <= ~xreq, state <= WAIT, all at that same edge.
REQ-015 In IDLE without s_valid, state, xreq and xdat SHALL hold.
REQ-016 In WAIT, at an edge where ack_s == xreq: state <= IDLE; s_ready is 1 after that edge.
REQ-017 Resulting latency: s_ready returns D+1 sclk edges after the first edge that samples the new xack level.
REQ-018 xdat SHALL NOT change while state is WAIT, regardless of s_valid or s_data.
REQ-019 In WAIT, s_valid is ignored; no transfer is accepted in the same cycle as the WAIT-to-IDLE transition.
REQ-020 An xack toggle while in IDLE (ack_s != xreq, spurious) SHALL be ignored and SHALL NOT block acceptance.
REQ-021 Throughput: at most one transfer per D+2 sclk cycles plus sink round-trip.

Reset
REQ-022 While srst is high: xreq=0, xdat=0, state=IDLE, synchronizer stages=0, s_ready=0, s_timeout=0 when present.
REQ-023 srst asserted in WAIT SHALL abort the transfer. The sink domain SHALL be reset concurrently so that its acknowledge toggle returns to 0. s_ready=1 on the first edge after srst deasserts.

Configuration
REQ-024 With macro HANDSHAKE_SYNC_TX_TIMEOUT_EN defined, the block SHALL add:
- output s_timeout (1 bit);
- a cycle counter cleared on entry to WAIT, saturating at TMO, incremented on each WAIT edge;
- s_timeout set to 1 at the edge the counter reaches TMO, sticky until srst.
The FSM SHALL keep waiting after timeout. Without the macro, neither the port nor the counter SHALL exist, and behaviour is otherwise identical.

Structure
REQ-025 A shared package handshake_sync_pkg SHALL hold:
- the state enum (IDLE, WAIT);
- default constants for N, D and TMO.
REQ-026 The D-stage synchronizer SHALL be a sub-module bit_sync (1-bit, parameter D, asynchronous active-high reset to 0).

Verification (N=8, D=2, TMO=16)
REQ-027 Reset: srst high gives xreq=0, xdat=0x00, s_ready=0; after deassert, s_ready=1 on the next edge.
REQ-028 Single transfer: s_data=0xA5 accepted at edge k gives xdat=0xA5, xreq=1, s_ready=0. Bench sets xack=1 sampled at edge k+4; s_ready=1 after edge k+7.
REQ-029 Back-to-back 0x01, 0x02, 0x03 with a 3-cycle responder: xreq sequence 1,0,1; xdat equals each value throughout its WAIT; all three accepted in order, none lost.
REQ-030 Hold: in WAIT, s_valid=1 with s_data changing 0x10 to 0x20 to 0x30: xdat stays at the accepted value; the next accept takes the s_data present in IDLE.
REQ-031 Reset mid-WAIT: xreq=1, srst pulsed 2 cycles gives xreq=0, state IDLE; the next transfer of 0x5A toggles xreq to 1.
REQ-032 Timeout (macro defined): no xack for 16 WAIT cycles gives s_timeout=1. A later xack toggle completes the transfer with s_timeout still 1, until srst.
